// File: rtl/dma_fifo_sequencer.sv
// Memory-to-memory DMA sequencer: reads a burst from src into an external registered
// FIFO, then replays it beat by beat to dst, with error abort and completion pulse.
//
// state  | meaning
// IDLE   | waiting for start; bus and FIFO strobes quiet
// READ   | bus read beats at src, each accepted beat pushed into the FIFO
// FETCH  | one-cycle pop; FIFO data appears in the following WRITE cycle
// WRITE  | bus write beat at dst carrying the popped FIFO word
// FINISH | completion: done + fifo_response pulse
// FAIL   | bad length or bus error: error set, done + fifo_response pulse
module dma_fifo_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         src_addr,
  input  logic [ADDR_WIDTH-1:0]         dst_addr,
  input  logic [$clog2(FIFO_DEPTH):0]   beat_count,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          bus_req,
  output logic                          bus_write,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  output logic [DATA_WIDTH-1:0]         bus_wdata,
  input  logic                          bus_ready,
  input  logic [DATA_WIDTH-1:0]         bus_rdata,
  input  logic                          bus_err,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_rdata,
  output logic                          fifo_response
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_FETCH, S_WRITE, S_FINISH, S_FAIL
  } state_t;

  state_t                state;
  logic [CW-1:0]         beats_q;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         wr_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  wr_first;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Push happens in the accepting cycle itself, so it cannot be registered.
  assign fifo_wr_en = (state == S_READ) && bus_ready && !bus_err;
  assign fifo_wdata = fifo_wr_en ? bus_rdata : '0;

  // The FIFO word is only guaranteed in the first WRITE cycle; hold it for stalls.
  assign bus_wdata = (state != S_WRITE) ? '0 : (wr_first ? fifo_rdata : wdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      bus_req       <= 1'b0;
      bus_write     <= 1'b0;
      bus_addr      <= '0;
      fifo_rd_en    <= 1'b0;
      fifo_response <= 1'b0;
      beats_q       <= '0;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      wr_addr_q     <= '0;
      wr_first      <= 1'b0;
      wdata_q       <= '0;
    end else begin
      done          <= 1'b0;
      fifo_response <= 1'b0;
      fifo_rd_en    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            beats_q   <= beat_count;
            wr_addr_q <= dst_addr;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
            if (beat_count == '0) begin
              state <= S_FINISH;
            end else if (beat_count > DEPTH_C) begin
              state <= S_FAIL;
            end else begin
              state     <= S_READ;
              bus_req   <= 1'b1;
              bus_write <= 1'b0;
              bus_addr  <= src_addr;
            end
          end
        end
        S_READ: begin
          if (bus_ready) begin
            if (bus_err) begin
              state   <= S_FAIL;
              bus_req <= 1'b0;
            end else begin
              rd_cnt <= rd_cnt + ONE_C;
              if (rd_cnt + ONE_C == beats_q) begin
                state      <= S_FETCH;
                bus_req    <= 1'b0;
                fifo_rd_en <= 1'b1;
              end else begin
                bus_addr <= bus_addr + STEP;
              end
            end
          end
        end
        S_FETCH: begin
          state     <= S_WRITE;
          bus_req   <= 1'b1;
          bus_write <= 1'b1;
          bus_addr  <= wr_addr_q;
          wr_first  <= 1'b1;
        end
        S_WRITE: begin
          if (wr_first) begin
            wdata_q  <= fifo_rdata;
            wr_first <= 1'b0;
          end
          if (bus_ready) begin
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            if (bus_err) begin
              state <= S_FAIL;
            end else begin
              wr_cnt    <= wr_cnt + ONE_C;
              wr_addr_q <= wr_addr_q + STEP;
              if (wr_cnt + ONE_C == beats_q) begin
                state <= S_FINISH;
              end else begin
                state      <= S_FETCH;
                fifo_rd_en <= 1'b1;
              end
            end
          end
        end
        S_FINISH: begin
          state         <= S_IDLE;
          busy          <= 1'b0;
          done          <= 1'b1;
          fifo_response <= 1'b1;
        end
        S_FAIL: begin
          state         <= S_IDLE;
          busy          <= 1'b0;
          error         <= 1'b1;
          done          <= 1'b1;
          fifo_response <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_fifo_sequencer.sv
// Directed bench for dma_fifo_sequencer: bus responder with stalls/errors, registered
// FIFO model, and a scoreboard of expected bus beats.
module tb_dma_fifo_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [3:0]  beat_count = '0;
  logic        busy, done, error, bus_req, bus_write;
  logic [31:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [15:0] bus_rdata;
  logic        bus_err = 1'b0;
  logic        fifo_wr_en, fifo_rd_en, fifo_response;
  logic [15:0] fifo_wdata;
  logic [15:0] fifo_rdata = '0;

  dma_fifo_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .beat_count(beat_count), .busy(busy), .done(done), .error(error),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .fifo_response(fifo_response)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          push;
    logic [31:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] fq[$];
  int n_tests = 0, n_fail = 0;
  int stall_cfg = 0, err_at = 0, wait_cnt = 0;
  int rd_beats = 0, wr_beats = 0, push_cnt = 0, pop_cnt = 0;
  int done_cnt = 0, resp_cnt = 0, req_seen = 0;
  logic [31:0] hold_addr;
  logic [15:0] hold_wdata;

  function automatic logic [15:0] mem_data(input logic [31:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {a[23:16], a[31:24]};
  endfunction

  assign bus_rdata = mem_data(bus_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Registered-output FIFO model; both pointers cleared by fifo_response or reset.
  always @(posedge clk) begin
    if (rst || fifo_response) begin
      fq.delete();
    end else begin
      if (fifo_wr_en) begin
        fq.push_back(fifo_wdata);
        push_cnt++;
      end
      if (fifo_rd_en) begin
        if (fq.size() > 0) fifo_rdata <= fq.pop_front();
        pop_cnt++;
      end
    end
  end

  // Bus responder and beat monitor.
  always @(negedge clk) begin
    if (rst) begin
      bus_ready = 1'b0;
      bus_err   = 1'b0;
      wait_cnt  = 0;
    end else begin
      if (done) done_cnt++;
      if (fifo_response) resp_cnt++;
      if (bus_req) begin
        req_seen++;
        if (wait_cnt == 0) begin
          hold_addr  = bus_addr;
          hold_wdata = bus_wdata;
        end else begin
          chk("stall_addr", 64'(bus_addr), 64'(hold_addr));
          if (bus_write) chk("stall_wdata", 64'(bus_wdata), 64'(hold_wdata));
        end
        if (wait_cnt < stall_cfg) begin
          bus_ready = 1'b0;
          bus_err   = 1'b0;
          wait_cnt++;
        end else begin
          bus_ready = 1'b1;
          bus_err   = !bus_write && (rd_beats + 1 == err_at);
          wait_cnt  = 0;
        end
      end else begin
        bus_ready = 1'b0;
        bus_err   = 1'b0;
        wait_cnt  = 0;
      end
      #1;
      if (fifo_wr_en && fifo_rd_en) chk("push_pop_overlap", 64'(1), 64'(0));
      if (bus_req && bus_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(bus_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_dir", 64'(bus_write), 64'(e.wr));
          chk("beat_addr", 64'(bus_addr), 64'(e.addr));
          if (e.wr) begin
            chk("wr_data", 64'(bus_wdata), 64'(e.data));
          end else begin
            chk("push_en", 64'(fifo_wr_en), 64'(e.push));
            if (e.push) chk("push_data", 64'(fifo_wdata), 64'(e.data));
          end
        end
        if (bus_write) wr_beats++; else rd_beats++;
      end
    end
  end

  task automatic push_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input int ea);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      if (ea != 0 && i + 1 > ea) break;
      b.wr = 1'b0; b.push = (i + 1 != ea); b.addr = s + 32'(2 * i); b.data = mem_data(b.addr);
      exp_q.push_back(b);
    end
    if (ea == 0) begin
      for (int i = 0; i < n; i++) begin
        beat_t b;
        b.wr = 1'b1; b.push = 1'b0; b.addr = d + 32'(2 * i); b.data = mem_data(s + 32'(2 * i));
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic clear_stats();
    rd_beats = 0; wr_beats = 0; push_cnt = 0; pop_cnt = 0;
    done_cnt = 0; resp_cnt = 0; req_seen = 0;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [3:0] n);
    @(negedge clk);
    src_addr = s; dst_addr = d; beat_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0 = done_cnt;
    int k = 0;
    while (done_cnt == c0 && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    chk("done_seen", 64'(done_cnt != c0), 64'(1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_bus_req", 64'(bus_req), 0);
    chk("rst_bus_write", 64'(bus_write), 0);
    chk("rst_bus_addr", 64'(bus_addr), 0);
    chk("rst_bus_wdata", 64'(bus_wdata), 0);
    chk("rst_fifo_strobes", 64'({fifo_wr_en, fifo_rd_en, fifo_response}), 0);
    chk("rst_fifo_wdata", 64'(fifo_wdata), 0);
    rst = 1'b0;

    // Four beats, no stalls.
    clear_stats(); stall_cfg = 0; err_at = 0;
    push_xfer(32'h100, 32'h200, 4, 0);
    do_start(32'h100, 32'h200, 4'd4);
    chk("t1_busy", 64'(busy), 1);
    wait_done(100);
    chk("t1_error", 64'(error), 0);
    chk("t1_resp", 64'(resp_cnt), 1);
    repeat (3) @(negedge clk);
    #2;
    chk("t1_done_once", 64'(done_cnt), 1);
    chk("t1_idle", 64'(busy), 0);
    chk("t1_beats", 64'({rd_beats[7:0], wr_beats[7:0]}), 64'h0404);
    chk("t1_exp_empty", 64'(exp_q.size()), 0);

    // Full FIFO, every beat stalled three cycles.
    clear_stats(); stall_cfg = 3;
    push_xfer(32'h1000, 32'h2000, 8, 0);
    do_start(32'h1000, 32'h2000, 4'd8);
    wait_done(600);
    chk("t2_pushes", 64'(push_cnt), 8);
    chk("t2_pops", 64'(pop_cnt), 8);
    chk("t2_error", 64'(error), 0);
    chk("t2_exp_empty", 64'(exp_q.size()), 0);

    // Zero-length transfer: done two cycles after start, no bus activity.
    clear_stats(); stall_cfg = 0;
    do_start(32'h100, 32'h200, 4'd0);
    chk("t3_busy", 64'(busy), 1);
    chk("t3_no_done_yet", 64'(done), 0);
    @(negedge clk);
    chk("t3_done", 64'(done), 1);
    chk("t3_resp", 64'(fifo_response), 1);
    chk("t3_error", 64'(error), 0);
    @(negedge clk);
    chk("t3_done_pulse", 64'(done), 0);
    chk("t3_no_req", 64'(req_seen), 0);

    // Over-length transfer fails without bus activity.
    clear_stats();
    do_start(32'h100, 32'h200, 4'd9);
    wait_done(10);
    chk("t3b_error", 64'(error), 1);
    chk("t3b_resp", 64'(resp_cnt), 1);
    chk("t3b_no_req", 64'(req_seen), 0);

    // Bus error on third read beat.
    clear_stats(); err_at = 3;
    push_xfer(32'h3000, 32'h3800, 4, 3);
    do_start(32'h3000, 32'h3800, 4'd4);
    wait_done(100);
    repeat (3) @(negedge clk);
    #2;
    chk("t4_error", 64'(error), 1);
    chk("t4_pushes", 64'(push_cnt), 2);
    chk("t4_done_once", 64'(done_cnt), 1);
    chk("t4_resp_once", 64'(resp_cnt), 1);
    chk("t4_no_writes", 64'(wr_beats), 0);
    chk("t4_exp_empty", 64'(exp_q.size()), 0);
    err_at = 0;

    // Reset during the second write beat, then a clean transfer.
    clear_stats(); stall_cfg = 3;
    push_xfer(32'h400, 32'h600, 4, 0);
    do_start(32'h400, 32'h600, 4'd4);
    chk("t5_error_cleared", 64'(error), 0);
    begin
      int k = 0;
      while (!(bus_req && bus_write && wr_beats == 1) && k < 300) begin
        @(negedge clk); #2;
        k++;
      end
      chk("t5_reached_wr2", 64'(bus_req && bus_write && wr_beats == 1), 1);
    end
    rst = 1'b1;
    @(negedge clk); #2;
    chk("t5_rst_outputs", 64'({busy, done, error, bus_req, bus_write, fifo_wr_en, fifo_rd_en, fifo_response}), 0);
    chk("t5_rst_addr", 64'(bus_addr), 0);
    chk("t5_rst_data", 64'({bus_wdata, fifo_wdata}), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    #2;
    chk("t5_no_done", 64'(done_cnt), 0);
    chk("t5_no_resp", 64'(resp_cnt), 0);
    clear_stats(); stall_cfg = 0;
    push_xfer(32'h700, 32'h800, 2, 0);
    do_start(32'h700, 32'h800, 4'd2);
    wait_done(100);
    chk("t5_recover_error", 64'(error), 0);
    chk("t5_recover_exp", 64'(exp_q.size()), 0);

    // Address wrap and start ignored while busy.
    clear_stats();
    push_xfer(32'hFFFF_FFFE, 32'h300, 2, 0);
    do_start(32'hFFFF_FFFE, 32'h300, 4'd2);
    src_addr = 32'h500; dst_addr = 32'h900; beat_count = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    repeat (5) @(negedge clk);
    #2;
    chk("t6_done_once", 64'(done_cnt), 1);
    chk("t6_beats", 64'({rd_beats[7:0], wr_beats[7:0]}), 64'h0202);
    chk("t6_exp_empty", 64'(exp_q.size()), 0);
    chk("t6_idle", 64'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
